score_bcd: RTL and testbench
============================

# score_bcd

Parametrised, sequential binary-to-BCD converter for the game's score display path. It converts CHANNELS unsigned scores in parallel using iterative shift-add-3, one bit per clock. Each channel produces DIGITS decimal digits with per-channel overflow saturation, and the block can optionally track a running high score. It sits between the score counters and the seven-segment multiplexer and replaces combinational divide/modulo digit extraction.

## Interface
- WIDTH, 7: bit width of each binary score.
- DIGITS, 3: decimal digits produced per channel.
- CHANNELS, 2: number of independent scores converted per pass.
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; samples `bin` when the block is idle.
- bin  input  CHANNELS*WIDTH  binary scores; channel c occupies bits [c*WIDTH +: WIDTH].
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when `bcd` updates.
- bcd  output  CHANNELS*DIGITS*4  results; channel c occupies bits [c*DIGITS*4 +: DIGITS*4], and digit 0 (ones) is the low nibble.
- overflow  output  CHANNELS  per channel, high when the value is ≥ 10^DIGITS; held with `bcd`.
- hs_clear  input  1  clears the high score (used only with the macro).
- hs_bcd  output  DIGITS*4  high score in BCD (used only with the macro).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: `busy` is 0.
  - On `start`=1: latch `bin` into per-channel shift registers, clear the BCD scratch and overflow scratch, load counter = WIDTH, go to SHIFT.
- SHIFT: `busy` is 1. Each cycle, for each channel:
  - Every scratch nibble ≥ 5 gets +3.
  - Then {scratch, shift} shifts left one bit.
  - If the bit shifted out of the top nibble is 1, set the channel's overflow scratch.
  - Counter decrements; when it reaches 1 on a shift cycle, go to DONE.
- DONE: `busy` is 1 for this cycle.
  - Copy scratch to `bcd` and the overflow scratch to `overflow`.
  - Pulse `done`, go to IDLE.
- Overflowed channels output all nibbles = 4'h9, not truncated digits.
- `start` while `busy`=1 is ignored and not queued.
- `start` asserted in the DONE cycle is ignored. The earliest accepted restart is the cycle after `done`.
- `bcd` and `overflow` hold their last values between `done` pulses.
- Reset mid-conversion returns the FSM to IDLE, clears all outputs, and discards the conversion.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `bcd`=0, `overflow`=0, `hs_bcd`=0.
  - Internal high score = 0, FSM = IDLE.
- `start` accepted at edge 0 → SHIFT for edges 1..WIDTH → DONE cycle → `done`=1 and new `bcd` visible after edge WIDTH+1.
- Latency is WIDTH+1 cycles; throughput is one conversion per WIDTH+2 cycles.
- `busy` rises the cycle after acceptance and falls together with the end of `done`.
- Outputs are fully registered; there are no combinational input-to-output paths.

## Configuration
- Macro: SCORE_BCD_HISCORE_EN.
- Defined:
  - An internal WIDTH-bit high-score register updates at `start` acceptance to the maximum of itself and all channels of `bin`.
  - The updated value is converted as an extra lane in the same pass.
  - `hs_bcd` updates on `done` and saturates to 9s if it overflows.
  - `hs_clear`=1 zeroes the register the next cycle. If it coincides with an accepted `start`, the clear happens first and the max is then taken over `bin` alone.
- Not defined:
  - No high-score logic.
  - `hs_bcd` is tied to 0 and `hs_clear` is ignored.

## Test plan
- Reset, defaults (WIDTH=7, DIGITS=3, CHANNELS=2): assert `reset` for 2 cycles → all outputs 0, `busy`=0.
- `bin`={99, 42}, pulse `start` → `done` exactly 8 cycles later; `bcd` ch0=12'h042, ch1=12'h099, `overflow`=2'b00.
- DIGITS=2, `bin`={127, 9} → ch0=8'h09, ch1=8'h99, `overflow`=2'b10.
- Pulse `start` at cycles 0 and 3 with different `bin` → exactly one `done`, at cycle 8, carrying the cycle-0 values.
- Assert `reset` at cycle 4 of a conversion → no `done` pulse; `bcd` stays 0; a new `start` afterwards converts correctly.
- With SCORE_BCD_HISCORE_EN defined:
  - Convert {30, 50}, then {10, 20} → `hs_bcd`=12'h050 after both passes.
  - Pulse `hs_clear`, then convert {7, 3} → `hs_bcd`=12'h007.

Source files
------------

// File: rtl/score_bcd.sv
// Sequential multi-channel binary-to-BCD converter (shift-add-3, one bit per clock) with
// per-channel overflow saturation. Optional running high score via SCORE_BCD_HISCORE_EN.
module score_bcd #(
    parameter int WIDTH    = 7,
    parameter int DIGITS   = 3,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CHANNELS*WIDTH-1:0]    bin,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS*DIGITS*4-1:0] bcd,
    output logic [CHANNELS-1:0]          overflow,
    input  logic                         hs_clear,
    output logic [DIGITS*4-1:0]          hs_bcd
);
    localparam int NW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SCORE_BCD_HISCORE_EN
    localparam int LANES = CHANNELS + 1;
`else
    localparam int LANES = CHANNELS;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                      state_reg;
    logic [CW-1:0]               count_reg;
    logic [WIDTH-1:0]            shift_reg [LANES];
    logic [NW-1:0]               scratch_reg [LANES];
    logic [LANES-1:0]            ovf_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic [CHANNELS*NW-1:0]      bcd_reg;
    logic [CHANNELS-1:0]         overflow_reg;

    logic [WIDTH-1:0]            load_val [LANES];
    logic [WIDTH-1:0]            shift_next [LANES];
    logic [NW-1:0]               scratch_next [LANES];
    logic [NW-1:0]               result [LANES];
    logic [LANES-1:0]            carry;

    genvar gi, gd;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_load
            assign load_val[gi] = bin[gi*WIDTH +: WIDTH];
        end
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [NW-1:0] adj;
            for (gd = 0; gd < DIGITS; gd++) begin : g_digit
                assign adj[gd*4 +: 4] = (scratch_reg[gi][gd*4 +: 4] >= 4'd5)
                                      ? scratch_reg[gi][gd*4 +: 4] + 4'd3
                                      : scratch_reg[gi][gd*4 +: 4];
            end
            // A bit leaving the top nibble means a digit beyond DIGITS would be non-zero.
            assign carry[gi]        = adj[NW-1];
            assign scratch_next[gi] = {adj[NW-2:0], shift_reg[gi][WIDTH-1]};
            assign shift_next[gi]   = shift_reg[gi] << 1;
            assign result[gi]       = ovf_reg[gi] ? {DIGITS{4'h9}} : scratch_reg[gi];
        end
    endgenerate

`ifdef SCORE_BCD_HISCORE_EN
    logic [WIDTH-1:0] hs_reg;
    logic [WIDTH-1:0] hs_max;
    logic [NW-1:0]    hs_bcd_reg;

    // A clear coinciding with an accepted start wins first, so the max covers bin alone.
    always_comb begin
        hs_max = hs_clear ? '0 : hs_reg;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bin[c*WIDTH +: WIDTH] > hs_max) hs_max = bin[c*WIDTH +: WIDTH];
        end
    end
    assign load_val[CHANNELS] = hs_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            hs_reg <= hs_max;
        end else if (hs_clear) begin
            hs_reg <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_bcd_reg <= '0;
        end else if (state_reg == DONE) begin
            hs_bcd_reg <= result[CHANNELS];
        end
    end
    assign hs_bcd = hs_bcd_reg;
`else
    logic unused_hs_clear;
    assign unused_hs_clear = hs_clear;
    assign hs_bcd = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= '0;
            ovf_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= '0;
            for (int l = 0; l < LANES; l++) begin
                shift_reg[l]   <= '0;
                scratch_reg[l] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // busy stays high through the done cycle, dropping here unless restarted.
                    busy_reg <= start;
                    if (start) begin
                        for (int l = 0; l < LANES; l++) begin
                            shift_reg[l]   <= load_val[l];
                            scratch_reg[l] <= '0;
                        end
                        ovf_reg   <= '0;
                        count_reg <= CW'(WIDTH);
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    for (int l = 0; l < LANES; l++) begin
                        shift_reg[l]   <= shift_next[l];
                        scratch_reg[l] <= scratch_next[l];
                    end
                    ovf_reg   <= ovf_reg | carry;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) state_reg <= DONE;
                end
                DONE: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        bcd_reg[c*NW +: NW] <= result[c];
                    end
                    overflow_reg <= ovf_reg[CHANNELS-1:0];
                    done_reg     <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign bcd      = bcd_reg;
    assign overflow = overflow_reg;
endmodule

// File: tb/tb_score_bcd.sv
// Directed bench for score_bcd: default instance plus a DIGITS=2 instance for overflow cases.
module tb_score_bcd;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy, done;
    logic [23:0] bcd;
    logic [1:0]  overflow;
    logic        hs_clear = 1'b0;
    logic [11:0] hs_bcd;

    logic        start2 = 1'b0;
    logic [13:0] bin2 = '0;
    logic        busy2, done2;
    logic [15:0] bcd2;
    logic [1:0]  overflow2;
    logic        hs_clear2 = 1'b0;
    logic [7:0]  hs_bcd2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    score_bcd dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin), .busy(busy), .done(done),
        .bcd(bcd), .overflow(overflow), .hs_clear(hs_clear), .hs_bcd(hs_bcd)
    );

    score_bcd #(.WIDTH(7), .DIGITS(2), .CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin(bin2), .busy(busy2), .done(done2),
        .bcd(bcd2), .overflow(overflow2), .hs_clear(hs_clear2), .hs_bcd(hs_bcd2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with b, then watch 14 edges recording done latency, pulse count and busy.
    task automatic run_conv(input logic [13:0] b, output int lat, output int ndone,
                            output logic b0, output logic b_done, output logic b_after);
        bin = b;
        start = 1'b1;
        tick();
        b0 = busy;
        start = 1'b0;
        lat = -1;
        ndone = 0;
        b_done = 1'b0;
        b_after = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    b_done = busy;
                end
            end
            if (lat > 0 && k == lat + 1) b_after = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (bcd !== 24'h0) begin bad++; $display("FAIL reset_bcd got=%h want=000000", bcd); end
        total++; if (overflow !== 2'b00) begin bad++; $display("FAIL reset_ovf got=%b want=00", overflow); end
        total++; if (hs_bcd !== 12'h0) begin bad++; $display("FAIL reset_hs got=%h want=000", hs_bcd); end
        total++; if (bcd2 !== 16'h0 || busy2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 got bcd=%h busy=%b want 0000/0", bcd2, busy2); end
        $display("reset: busy=%b done=%b bcd=%h ovf=%b", busy, done, bcd, overflow);
    endtask

    task automatic test_convert();
        logic [13:0] vin  [3] = '{{7'd99, 7'd42}, {7'd127, 7'd0}, {7'd100, 7'd5}};
        logic [23:0] vexp [3] = '{24'h099042, 24'h127000, 24'h100005};
        int lat, nd;
        logic b0, bd, ba;
        for (int i = 0; i < 3; i++) begin
            run_conv(vin[i], lat, nd, b0, bd, ba);
            total++; if (lat != 8) begin bad++; $display("FAIL conv%0d_latency got=%0d want=8", i, lat); end
            total++; if (nd != 1) begin bad++; $display("FAIL conv%0d_done_count got=%0d want=1", i, nd); end
            total++; if (bcd !== vexp[i]) begin bad++; $display("FAIL conv%0d_bcd got=%h want=%h", i, bcd, vexp[i]); end
            total++; if (overflow !== 2'b00) begin bad++; $display("FAIL conv%0d_ovf got=%b want=00", i, overflow); end
            total++; if ({b0, bd, ba} !== 3'b110) begin bad++; $display("FAIL conv%0d_busy got=%b want=110", i, {b0, bd, ba}); end
            $display("convert: bin=%h lat=%0d bcd=%h ovf=%b", vin[i], lat, bcd, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [13:0] vin  [3] = '{{7'd127, 7'd9}, {7'd99, 7'd100}, {7'd10, 7'd99}};
        logic [15:0] vexp [3] = '{16'h9909, 16'h9999, 16'h1099};
        logic [1:0]  oexp [3] = '{2'b10, 2'b01, 2'b00};
        int lat;
        for (int i = 0; i < 3; i++) begin
            bin2 = vin[i];
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            lat = -1;
            for (int k = 1; k <= 14; k++) begin
                tick();
                if (done2 && lat < 0) lat = k;
            end
            total++; if (lat != 8) begin bad++; $display("FAIL ovf%0d_latency got=%0d want=8", i, lat); end
            total++; if (bcd2 !== vexp[i]) begin bad++; $display("FAIL ovf%0d_bcd got=%h want=%h", i, bcd2, vexp[i]); end
            total++; if (overflow2 !== oexp[i]) begin bad++; $display("FAIL ovf%0d_flags got=%b want=%b", i, overflow2, oexp[i]); end
            $display("overflow: bin=%h bcd=%h ovf=%b", vin[i], bcd2, overflow2);
        end
    endtask

    // Restart attempts at edge 3 (busy) and edge 8 (DONE state) must both be dropped.
    task automatic test_ignore_start();
        int lat = -1;
        int nd = 0;
        bin = {7'd11, 7'd22};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                nd++;
                if (lat < 0) lat = k;
            end
            start = (k == 2 || k == 7);
            if (k == 2) bin = {7'd33, 7'd44};
            if (k == 7) bin = {7'd55, 7'd66};
        end
        start = 1'b0;
        total++; if (nd != 1 || lat != 8) begin bad++; $display("FAIL ignore_done got count=%0d lat=%0d want 1/8", nd, lat); end
        total++; if (bcd !== 24'h011022) begin bad++; $display("FAIL ignore_bcd got=%h want=011022", bcd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b want=0", busy); end
        $display("ignore_start: dones=%0d lat=%0d bcd=%h", nd, lat, bcd);
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int lat, nd2;
        logic b0, bd, ba;
        bin = {7'd50, 7'd60};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (done) nd++;
            reset = (k == 3);
        end
        reset = 1'b0;
        total++; if (nd != 0) begin bad++; $display("FAIL rmid_done got=%0d want=0", nd); end
        total++; if (bcd !== 24'h0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_state got bcd=%h busy=%b want 000000/0", bcd, busy); end
        run_conv({7'd1, 7'd2}, lat, nd2, b0, bd, ba);
        total++; if (lat != 8 || bcd !== 24'h001002) begin bad++; $display("FAIL rmid_after got lat=%0d bcd=%h want 8/001002", lat, bcd); end
        $display("reset_mid: dones=%0d then bcd=%h", nd, bcd);
    endtask

    task automatic test_back_to_back();
        int lat, nd;
        logic b0, bd, ba;
        run_conv({7'd64, 7'd8}, lat, nd, b0, bd, ba);
        bin = {7'd77, 7'd77};
        for (int k = 0; k < 5; k++) tick();
        total++; if (bcd !== 24'h064008) begin bad++; $display("FAIL hold_bcd got=%h want=064008", bcd); end
        run_conv({7'd123, 7'd45}, lat, nd, b0, bd, ba);
        total++; if (lat != 8 || bcd !== 24'h123045) begin bad++; $display("FAIL b2b_second got lat=%0d bcd=%h want 8/123045", lat, bcd); end
        $display("back_to_back: bcd=%h", bcd);
    endtask

    task automatic test_hiscore();
        int lat, nd;
        logic b0, bd, ba;
`ifdef SCORE_BCD_HISCORE_EN
        run_conv({7'd30, 7'd50}, lat, nd, b0, bd, ba);
        run_conv({7'd10, 7'd20}, lat, nd, b0, bd, ba);
        total++; if (hs_bcd !== 12'h050) begin bad++; $display("FAIL hs_max got=%h want=050", hs_bcd); end
        hs_clear = 1'b1;
        tick();
        hs_clear = 1'b0;
        run_conv({7'd7, 7'd3}, lat, nd, b0, bd, ba);
        total++; if (hs_bcd !== 12'h007) begin bad++; $display("FAIL hs_clear got=%h want=007", hs_bcd); end
        hs_clear = 1'b1;
        run_conv({7'd2, 7'd1}, lat, nd, b0, bd, ba);
        hs_clear = 1'b0;
        total++; if (hs_bcd !== 12'h002) begin bad++; $display("FAIL hs_clear_start got=%h want=002", hs_bcd); end
`else
        hs_clear = 1'b1;
        run_conv({7'd90, 7'd80}, lat, nd, b0, bd, ba);
        hs_clear = 1'b0;
        total++; if (hs_bcd !== 12'h000) begin bad++; $display("FAIL hs_disabled got=%h want=000", hs_bcd); end
        total++; if (bcd !== 24'h090080) begin bad++; $display("FAIL hs_disabled_bcd got=%h want=090080", bcd); end
`endif
        $display("hiscore: hs_bcd=%h", hs_bcd);
    endtask

    initial begin
        tick();
        test_reset();
        test_convert();
        test_overflow();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_hiscore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
